// File: rtl/bcd_countdown_timer_if.sv
// Control and display bundle of the BCD countdown timer.
// The controller drives the i_* signals; the timer drives the o_* signals.
interface bcd_countdown_timer_if #(
  parameter int DIGITS = 4
);
  logic                  i_load;
  logic [4*DIGITS-1:0]   i_load_val;
  logic                  i_start;
  logic                  i_pause;
  logic [4*DIGITS-1:0]   o_digits;
  logic                  o_running;
  logic                  o_tick;
  logic                  o_done;

  modport master (
    output i_load, i_load_val, i_start, i_pause,
    input  o_digits, o_running, o_tick, o_done
  );

  modport slave (
    input  i_load, i_load_val, i_start, i_pause,
    output o_digits, o_running, o_tick, o_done
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with per-digit modulus, prescaler,
// load/start/pause control and optional auto-reload.
module bcd_countdown_timer #(
  parameter int                    DIGITS    = 4,
  parameter logic [4*DIGITS-1:0]   DIGIT_MAX = 16'h5959,
  parameter int                    TICK_DIV  = 50000000,
  parameter bit                    RELOAD    = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bcd_countdown_timer_if.slave   bus
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t          state_q;
  logic [W-1:0]    count_q;
  logic [W-1:0]    reload_q;
  logic [PW-1:0]   presc_q;
  logic            running_q;
  logic            tick_q;
  logic            done_q;

  logic [W-1:0]    load_clamped_d;
  logic [W-1:0]    count_dec_d;
  logic            count_zero_d;
  logic            dec_zero_d;
  logic            reload_zero_d;
  logic            start_ok_d;
  logic            pause_ok_d;

  // Any digit above its modulus (including A..F) saturates to that digit's maximum.
  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = {W{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > DIGIT_MAX[4*i +: 4]) begin
        r[4*i +: 4] = DIGIT_MAX[4*i +: 4];
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Ripple-borrow decrement: a borrowing digit at 0 wraps to its own maximum.
  function automatic logic [W-1:0] dec_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = {W{1'b0}};
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!borrow) begin
        r[4*i +: 4] = v[4*i +: 4];
      end else if (v[4*i +: 4] == 4'd0) begin
        r[4*i +: 4] = DIGIT_MAX[4*i +: 4];
      end else begin
        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
        borrow      = 1'b0;
      end
    end
    return r;
  endfunction

  // Next-value helpers and command qualification.
  always_comb begin
    load_clamped_d = clamp_bcd(bus.i_load_val);
    count_dec_d    = dec_bcd(count_q);
    count_zero_d   = (count_q == {W{1'b0}});
    dec_zero_d     = (count_dec_d == {W{1'b0}});
    reload_zero_d  = (reload_q == {W{1'b0}});
    start_ok_d     = bus.i_start && !bus.i_pause && (state_q != ST_RUN) && !count_zero_d;
    pause_ok_d     = bus.i_pause && !bus.i_start && (state_q == ST_RUN);
  end

  // Timer FSM with registered count, reload value and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= {W{1'b0}};
      reload_q  <= {W{1'b0}};
      presc_q   <= {PW{1'b0}};
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      if (bus.i_load) begin
        count_q   <= load_clamped_d;
        reload_q  <= load_clamped_d;
        presc_q   <= {PW{1'b0}};
        state_q   <= ST_IDLE;
        running_q <= 1'b0;
      end else if (start_ok_d) begin
        // Resuming from PAUSE keeps the partial prescaler period.
        if (state_q == ST_IDLE) begin
          presc_q <= {PW{1'b0}};
        end else begin
          presc_q <= presc_q;
        end
        state_q   <= ST_RUN;
        running_q <= 1'b1;
      end else if (pause_ok_d) begin
        state_q   <= ST_PAUSE;
        running_q <= 1'b0;
      end else begin
        case (state_q)
          ST_RUN: begin
            if (presc_q == PRESC_LAST) begin
              presc_q <= {PW{1'b0}};
              tick_q  <= 1'b1;
              if (count_zero_d) begin
                // Only reachable with auto-reload: zero has been shown for a full period.
                if (RELOAD && !reload_zero_d) begin
                  count_q <= reload_q;
                end else begin
                  state_q   <= ST_IDLE;
                  running_q <= 1'b0;
                end
              end else begin
                count_q <= count_dec_d;
                if (dec_zero_d) begin
                  done_q <= 1'b1;
                  if (!RELOAD || reload_zero_d) begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                  end else begin
                    state_q <= ST_RUN;
                  end
                end else begin
                  state_q <= ST_RUN;
                end
              end
            end else begin
              presc_q <= presc_q + PW'(1);
            end
          end
          ST_IDLE, ST_PAUSE: begin
            state_q <= state_q;
          end
          default: begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_digits  = count_q;
  assign bus.o_running = running_q;
  assign bus.o_tick    = tick_q;
  assign bus.o_done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: a stop-at-zero and an auto-reload instance share
// stimulus and are compared each cycle against an integer-valued reference model.
module tb_bcd_countdown_timer;
  localparam int          DIGITS = 4;
  localparam logic [15:0] DMAX   = 16'h5959;
  localparam int          TDIV   = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  bcd_countdown_timer_if #(.DIGITS(DIGITS)) bus0 ();
  bcd_countdown_timer_if #(.DIGITS(DIGITS)) bus1 ();

  bcd_countdown_timer #(.DIGITS(DIGITS), .DIGIT_MAX(DMAX), .TICK_DIV(TDIV), .RELOAD(1'b0))
    u_stop (.clk(clk), .rst_n(rst_n), .bus(bus0));
  bcd_countdown_timer #(.DIGITS(DIGITS), .DIGIT_MAX(DMAX), .TICK_DIV(TDIV), .RELOAD(1'b1))
    u_rel (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: count held as a plain integer in the mixed-radix number system.
  int m_cnt  [2];
  int m_rel  [2];
  int m_mode [2];   // 0 idle, 1 run, 2 pause
  int m_ph   [2];   // cycles elapsed in the current tick period
  bit m_tick [2];
  bit m_done [2];

  function automatic int dmax(input int i);
    return int'((DMAX >> (4 * i)) & 16'h000F);
  endfunction

  function automatic int bcd_to_int(input logic [15:0] v);
    int n, w, d;
    n = 0; w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'((v >> (4 * i)) & 16'h000F);
      if (d > dmax(i)) d = dmax(i);
      n += d * w;
      w *= dmax(i) + 1;
    end
    return n;
  endfunction

  function automatic logic [15:0] int_to_bcd(input int n);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < DIGITS; i++) begin
      r = r | (16'(n % (dmax(i) + 1)) << (4 * i));
      n = n / (dmax(i) + 1);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_rel[k] = 0; m_mode[k] = 0; m_ph[k] = 0;
      m_tick[k] = 1'b0; m_done[k] = 1'b0;
    end
  endtask

  task automatic model_clock(input int k, input bit ld, input logic [15:0] val,
                             input bit st, input bit pa);
    bit rel_mode;
    rel_mode  = (k == 1);
    m_tick[k] = 1'b0;
    m_done[k] = 1'b0;
    if (ld) begin
      m_cnt[k] = bcd_to_int(val); m_rel[k] = m_cnt[k]; m_ph[k] = 0; m_mode[k] = 0;
    end else if (st && !pa && m_mode[k] != 1 && m_cnt[k] != 0) begin
      if (m_mode[k] == 0) m_ph[k] = 0;
      m_mode[k] = 1;
    end else if (pa && !st && m_mode[k] == 1) begin
      m_mode[k] = 2;
    end else if (m_mode[k] == 1) begin
      m_ph[k]++;
      if (m_ph[k] == TDIV) begin
        m_ph[k]   = 0;
        m_tick[k] = 1'b1;
        if (m_cnt[k] == 0) begin
          if (rel_mode && m_rel[k] != 0) m_cnt[k] = m_rel[k];
          else m_mode[k] = 0;
        end else begin
          m_cnt[k]--;
          if (m_cnt[k] == 0) begin
            m_done[k] = 1'b1;
            if (!rel_mode || m_rel[k] == 0) m_mode[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("stop.digits",  32'(bus0.o_digits),  32'(int_to_bcd(m_cnt[0])));
    check("stop.running", 32'(bus0.o_running), 32'(m_mode[0] == 1));
    check("stop.tick",    32'(bus0.o_tick),    32'(m_tick[0]));
    check("stop.done",    32'(bus0.o_done),    32'(m_done[0]));
    check("rel.digits",   32'(bus1.o_digits),  32'(int_to_bcd(m_cnt[1])));
    check("rel.running",  32'(bus1.o_running), 32'(m_mode[1] == 1));
    check("rel.tick",     32'(bus1.o_tick),    32'(m_tick[1]));
    check("rel.done",     32'(bus1.o_done),    32'(m_done[1]));
  endtask

  // One clock: drive both instances, advance the model on the edge, check 1 ns later.
  task automatic cyc(input bit ld, input logic [15:0] val, input bit st, input bit pa);
    bus0.i_load = ld; bus0.i_load_val = val; bus0.i_start = st; bus0.i_pause = pa;
    bus1.i_load = ld; bus1.i_load_val = val; bus1.i_start = st; bus1.i_pause = pa;
    @(posedge clk);
    model_clock(0, ld, val, st, pa);
    model_clock(1, ld, val, st, pa);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus0.i_load = 1'b0; bus0.i_load_val = 16'h0000; bus0.i_start = 1'b0; bus0.i_pause = 1'b0;
    bus1.i_load = 1'b0; bus1.i_load_val = 16'h0000; bus1.i_start = 1'b0; bus1.i_pause = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // 1: 0102 counts 0101, 0100, 0059, 0058 one step per 4 clk
    cyc(1'b1, 16'h0102, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    idle(16);
    // 2: 0002 reaches zero with one done; stop instance holds, reload instance reloads
    cyc(1'b1, 16'h0002, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    idle(30);
    // 3: pause two cycles into a period, hold, then resume
    cyc(1'b1, 16'h0005, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    idle(2);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1);
    idle(10);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    idle(6);
    cyc(1'b0, 16'h0000, 1'b1, 1'b1);
    idle(3);
    // 4: clamping of out-of-range digits, and start ignored at zero
    cyc(1'b1, 16'h9F9A, 1'b0, 1'b0);
    cyc(1'b1, 16'h0000, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    idle(8);
    // 6: async reset mid-run, and load winning over start in the same cycle
    cyc(1'b1, 16'h0030, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    idle(5);
    async_reset();
    idle(2);
    cyc(1'b1, 16'h0011, 1'b1, 1'b0);
    idle(3);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    idle(9);

    // Random traffic: sparse loads of arbitrary nibbles, frequent start/pause.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] v;
      bit ld, st, pa;
      v  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) v = v & 16'h0013;
      ld = ($urandom_range(0, 59) == 0);
      st = ($urandom_range(0, 7) == 0);
      pa = ($urandom_range(0, 15) == 0);
      cyc(ld, v, st, pa);
      if ($urandom_range(0, 999) == 0) async_reset();
    end
    async_reset();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
